// File: rtl/serial_tx_piso.sv
// Framed parallel-in/serial-out transmitter: start bit, WIDTH data bits LSB first,
// optional even parity (macro SERIAL_TX_PARITY_EN), stop bit; each bit held DIV cycles.
module serial_tx_piso #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             tx,
    output logic             done
);

    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [TW-1:0]    tick_q;
    logic [TW-1:0]    tick_d;
    logic             tick_end;
    logic [BW-1:0]    bit_q;
    logic             tx_q;
    logic             ready_q;
    logic             done_q;
`ifdef SERIAL_TX_PARITY_EN
    logic             parity_q;
`endif

    // The tick counter restarts at every bit boundary, so it never wraps mid-bit.
    assign tick_end = (tick_q == TICK_LAST);
    assign tick_d   = tick_end ? '0 : tick_q + 1'b1;
    assign shift_d  = shift_q >> 1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            tick_q   <= '0;
            bit_q    <= '0;
            tx_q     <= 1'b1;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tick_q  <= '0;
                    bit_q   <= '0;
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                    if (load) begin
                        shift_q  <= data_in;
`ifdef SERIAL_TX_PARITY_EN
                        parity_q <= ^data_in;
`endif
                        state_q  <= S_START;
                        tx_q     <= 1'b0;
                        ready_q  <= 1'b0;
                    end
                end
                S_START: begin
                    tick_q <= tick_d;
                    if (tick_end) begin
                        state_q <= S_DATA;
                        tx_q    <= shift_q[0];
                    end
                end
                S_DATA: begin
                    tick_q <= tick_d;
                    if (tick_end) begin
                        shift_q <= shift_d;
                        if (bit_q == BIT_LAST) begin
                            bit_q   <= '0;
`ifdef SERIAL_TX_PARITY_EN
                            state_q <= S_PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_q <= bit_q + 1'b1;
                            tx_q  <= shift_d[0];
                        end
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                S_PARITY: begin
                    tick_q <= tick_d;
                    if (tick_end) begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    tick_q <= tick_d;
                    tx_q   <= 1'b1;
                    if (tick_end) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tick_q  <= '0;
                    bit_q   <= '0;
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign tx    = tx_q;
    assign ready = ready_q;
    assign done  = done_q;

endmodule

// File: tb/tb_serial_tx_piso.sv
// Randomized self-checking bench for serial_tx_piso: one instance WIDTH=8/DIV=4,
// one instance WIDTH=4/DIV=1, checked cycle by cycle against a frame-level model.
module tb_serial_tx_piso;

`ifdef SERIAL_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data0 = '0;
    logic       load0 = 1'b0;
    logic       ready0, tx0, done0;
    logic [3:0] data1 = '0;
    logic       load1 = 1'b0;
    logic       ready1, tx1, done1;

    int checks = 0;
    int errors = 0;

    serial_tx_piso #(.WIDTH(8), .DIV(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .data_in(data0), .load(load0),
        .ready(ready0), .tx(tx0), .done(done0)
    );

    serial_tx_piso #(.WIDTH(4), .DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(data1), .load(load1),
        .ready(ready1), .tx(tx1), .done(done1)
    );

    initial forever #5 clk = ~clk;

    function automatic logic get_tx(input int sel);
        return (sel != 0) ? tx1 : tx0;
    endfunction

    function automatic logic get_ready(input int sel);
        return (sel != 0) ? ready1 : ready0;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel != 0) ? done1 : done0;
    endfunction

    function automatic int width_of(input int sel);
        return (sel != 0) ? 4 : 8;
    endfunction

    function automatic int div_of(input int sel);
        return (sel != 0) ? 1 : 4;
    endfunction

    function automatic int frame_len(input int sel);
        return (width_of(sel) + 2 + PAR) * div_of(sel);
    endfunction

    // Expected line level in cycle k (1-based) after the accepting edge.
    function automatic logic exp_bit(input int sel, input logic [7:0] w, input int k);
        int width, idx;
        logic par;
        width = width_of(sel);
        idx = (k - 1) / div_of(sel);
        par = 1'b0;
        for (int i = 0; i < width; i++) par = par ^ w[i];
        if (idx == 0) return 1'b0;
        if (idx <= width) return w[idx-1];
        if (PAR == 1 && idx == width + 1) return par;
        return 1'b1;
    endfunction

    task automatic drive(input int sel, input logic l, input logic [7:0] d);
        if (sel != 0) begin
            load1 = l;
            data1 = d[3:0];
        end else begin
            load0 = l;
            data0 = d;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input int sel, input string name);
        checks++;
        if ({get_tx(sel), get_ready(sel), get_done(sel)} !== 3'b110) begin
            errors++;
            $display("FAIL %s dut%0d tx/ready/done got %b%b%b want 110",
                     name, sel, get_tx(sel), get_ready(sel), get_done(sel));
        end
    endtask

    // Starts in a cycle with ready=1 and ends in the done cycle with load=0.
    task automatic send_frame(input int sel, input logic [7:0] w, input bit busy_load);
        int f;
        f = frame_len(sel);
        checks++;
        if (get_ready(sel) !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_load dut%0d got %b want 1", sel, get_ready(sel));
        end
        drive(sel, 1'b1, w);
        step();
        for (int k = 1; k <= f; k++) begin
            drive(sel, busy_load, 8'($urandom));
            checks++;
            if (get_tx(sel) !== exp_bit(sel, w, k)) begin
                errors++;
                $display("FAIL frame_tx dut%0d word %h cycle N+%0d got %b want %b",
                         sel, w, k, get_tx(sel), exp_bit(sel, w, k));
            end
            checks++;
            if ({get_ready(sel), get_done(sel)} !== 2'b00) begin
                errors++;
                $display("FAIL frame_busy dut%0d word %h cycle N+%0d ready/done got %b%b want 00",
                         sel, w, k, get_ready(sel), get_done(sel));
            end
            step();
        end
        drive(sel, 1'b0, 8'h00);
        checks++;
        if ({get_tx(sel), get_ready(sel), get_done(sel)} !== 3'b111) begin
            errors++;
            $display("FAIL done_cycle dut%0d word %h cycle N+%0d tx/ready/done got %b%b%b want 111",
                     sel, w, f + 1, get_tx(sel), get_ready(sel), get_done(sel));
        end
    endtask

    task automatic idle_cycles(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check_idle(sel, "idle_gap");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check_idle(0, "reset_idle");
            check_idle(1, "reset_idle");
            step();
        end
    endtask

    task automatic test_basic();
        send_frame(0, 8'hA5, 1'b0);
        idle_cycles(0, 2);
        send_frame(0, 8'h07, 1'b0);
        idle_cycles(0, 1);
    endtask

    task automatic test_busy_load();
        send_frame(0, 8'($urandom), 1'b1);
        idle_cycles(0, 1);
    endtask

    task automatic test_back_to_back();
        send_frame(0, 8'($urandom), 1'b0);
        send_frame(0, 8'h3C, 1'b0);
        idle_cycles(0, 1);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] w;
        w = 8'($urandom);
        drive(0, 1'b1, w);
        step();
        drive(0, 1'b0, 8'h00);
        // Cycles N+17..N+20 carry data bit 3; reset lands in N+18.
        for (int k = 1; k <= 18; k++) begin
            checks++;
            if (tx0 !== exp_bit(0, w, k)) begin
                errors++;
                $display("FAIL pre_reset_tx cycle N+%0d got %b want %b", k, tx0, exp_bit(0, w, k));
            end
            if (k < 18) step();
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_idle(0, "after_mid_reset");
        idle_cycles(0, 8);
        send_frame(0, 8'h81, 1'b0);
        idle_cycles(0, 1);
    endtask

    task automatic test_div1();
        send_frame(1, 8'h09, 1'b0);
        idle_cycles(1, 1);
        send_frame(1, 8'($urandom), 1'b1);
        send_frame(1, 8'($urandom), 1'b0);
        idle_cycles(1, 2);
    endtask

    task automatic test_random();
        int sel;
        for (int t = 0; t < 12; t++) begin
            sel = int'($urandom_range(0, 1));
            send_frame(sel, 8'($urandom), bit'($urandom_range(0, 1)));
            idle_cycles(sel, int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_busy_load();
        test_back_to_back();
        test_reset_mid_frame();
        test_div1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
